// File: rtl/forest_vote_sched_pkg.sv
// forest_pkg: shared sizes, FSM state type and vote-counter array type for forest_vote_sched
package forest_pkg;
    localparam int N_FEAT    = 51;
    localparam int N_CLASS   = 6;
    localparam int N_TREE    = 4;
    localparam int MIN_VOTES = 2;
    localparam int TSEL_W    = (N_TREE > 1) ? $clog2(N_TREE) : 1;
    localparam int CLS_W     = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam int CNT_W     = $clog2(N_TREE + 1);

    typedef enum logic [1:0] {IDLE, EVAL, ARGMAX, DONE} state_t;

    typedef logic [N_CLASS-1:0][CNT_W-1:0] cnt_arr_t;
endpackage

// File: rtl/forest_vote_sched_argmax.sv
// vote_argmax: serial argmax over the vote counters, one class per cycle, ties keep the lower index
module vote_argmax
    import forest_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  cnt_arr_t         i_cnt,
    output logic             o_done,
    output logic [CLS_W-1:0] o_idx,
    output logic [CNT_W-1:0] o_score
);
    logic             r_busy;
    logic [CLS_W-1:0] r_idx;
    logic [CLS_W-1:0] r_best_idx;
    logic [CNT_W-1:0] r_best_score;
    logic             w_gt;

    // compare the current class against the running best; the result including it is visible on the outputs
    always_comb begin
        w_gt    = i_cnt[r_idx] > r_best_score;
        o_done  = r_busy && (r_idx == CLS_W'(N_CLASS - 1));
        o_idx   = w_gt ? r_idx : r_best_idx;
        o_score = w_gt ? i_cnt[r_idx] : r_best_score;
    end

    // walk the classes; the best starts at class 0 with score 0 so all-zero votes yield class 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
        end else if (i_start) begin
            r_busy       <= 1'b1;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
        end else if (r_busy) begin
            r_best_idx   <= o_idx;
            r_best_score <= o_score;
            r_idx        <= r_idx + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/forest_vote_sched.sv
// forest_vote_sched: steps the tree bank, counts per-class votes and returns the winning class
// Optional reject flag built only when FVS_REJECT_EN is defined.
module forest_vote_sched
    import forest_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic [N_FEAT-1:0] feat_o,
    output logic [TSEL_W-1:0] tree_sel_o,
    input  logic [N_CLASS-1:0] tree_vote_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic [CNT_W-1:0]  out_score,
    output logic              out_reject
);
    state_t            r_state;
    state_t            w_next;
    logic [N_FEAT-1:0] r_feat;
    logic [TSEL_W-1:0] r_sel;
    cnt_arr_t          r_cnt;
    logic [CLS_W-1:0]  r_class;
    logic [CNT_W-1:0]  r_score;
    logic              w_last;
    logic              w_start;
    logic              w_done;
    logic [CLS_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_best;

    assign feat_o     = r_feat;
    assign tree_sel_o = r_sel;
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_class  = r_class;
    assign out_score  = r_score;

    vote_argmax u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_cnt   (r_cnt),
        .o_done  (w_done),
        .o_idx   (w_idx),
        .o_score (w_best)
    );

    // next-state decode; argmax starts on the edge that takes the last tree sample
    always_comb begin
        w_next  = r_state;
        w_last  = (r_sel == TSEL_W'(N_TREE - 1));
        w_start = (r_state == EVAL) && w_last;
        case (r_state)
            IDLE:    w_next = in_valid ? EVAL : IDLE;
            EVAL:    w_next = w_last ? ARGMAX : EVAL;
            ARGMAX:  w_next = w_done ? DONE : ARGMAX;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // state, feature latch, tree stepping, vote counting and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_feat  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_class <= '0;
            r_score <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_feat <= in_feat;
                r_cnt  <= '0;
                r_sel  <= '0;
            end
            if (r_state == EVAL) begin
                for (int c = 0; c < N_CLASS; c++)
                    r_cnt[c] <= r_cnt[c] + CNT_W'(tree_vote_i[c]);
                r_sel <= w_last ? '0 : r_sel + 1'b1;
            end
            if (r_state == ARGMAX && w_done) begin
                r_class <= w_idx;
                r_score <= w_best;
            end
        end
    end

`ifdef FVS_REJECT_EN
    logic r_reject;

    // reject flag registered alongside the winning class
    always_ff @(posedge clk) begin
        if (!rst_n) r_reject <= 1'b0;
        else if (r_state == ARGMAX && w_done) r_reject <= (w_best < CNT_W'(MIN_VOTES));
    end

    assign out_reject = r_reject;
`else
    assign out_reject = 1'b0;
`endif
endmodule

// File: tb/tb_forest_vote_sched.sv
// tb_forest_vote_sched: directed scoreboard bench for forest_vote_sched with a modelled tree bank
module tb_forest_vote_sched;
    import forest_pkg::*;

    typedef struct packed {
        logic [CLS_W-1:0] c;
        logic [CNT_W-1:0] s;
        logic             r;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic [N_FEAT-1:0]  in_feat = '0;
    logic               in_ready;
    logic [N_FEAT-1:0]  feat_o;
    logic [TSEL_W-1:0]  tree_sel_o;
    logic [N_CLASS-1:0] tree_vote_i;
    logic               out_valid;
    logic [CLS_W-1:0]   out_class;
    logic [CNT_W-1:0]   out_score;
    logic               out_reject;
    logic [N_CLASS-1:0] votes [N_TREE];
    exp_t               sb [$];
    int                 total = 0;
    int                 bad = 0;

    always #5 clk = ~clk;

    // tree bank model: combinational vote pattern selected by the tree index
    assign tree_vote_i = votes[tree_sel_o];

    forest_vote_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_feat     (in_feat),
        .feat_o      (feat_o),
        .tree_sel_o  (tree_sel_o),
        .tree_vote_i (tree_vote_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_score   (out_score),
        .out_reject  (out_reject)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        int   cnt [N_CLASS];
        exp_t e;
        int   bs;
        e  = '0;
        bs = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            cnt[c] = 0;
            for (int t = 0; t < N_TREE; t++) cnt[c] += int'(votes[t][c]);
            if (cnt[c] > bs) begin
                bs  = cnt[c];
                e.c = CLS_W'(c);
            end
        end
        e.s = CNT_W'(bs);
`ifdef FVS_REJECT_EN
        e.r = (bs < MIN_VOTES);
`else
        e.r = 1'b0;
`endif
        return e;
    endfunction

    task automatic set_votes(input logic [N_CLASS-1:0] v0, v1, v2, v3);
        votes[0] = v0;
        votes[1] = v1;
        votes[2] = v2;
        votes[3] = v3;
    endtask

    // called at a negedge in IDLE; returns at the negedge after the accept edge
    task automatic send(input bit push, input int hold);
        logic [N_FEAT-1:0] f;
        f = N_FEAT'({$urandom(), $urandom()});
        in_feat   = f;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", in_ready, 1);
        if (push) sb.push_back(model());
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_feat  = ~f;
        chk("feat_latched", feat_o, f);
    endtask

    task automatic collect(input int hold);
        int   n;
        exp_t e;
        n = 1;
        while (!out_valid && n < 40) begin
            if (n <= N_TREE) chk("tree_sel_seq", tree_sel_o, n - 1);
            @(negedge clk);
            n++;
        end
        chk("latency_edge", n, N_TREE + N_CLASS + 1);
        if (n >= 40 || sb.size() == 0) return;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_class", out_class, sb[0].c);
            chk("bp_score", out_score, sb[0].s);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        chk("out_class", out_class, e.c);
        chk("out_score", out_score, e.s);
        chk("out_reject", out_reject, e.r);
        chk("done_in_ready", in_ready, 0);
        @(negedge clk);
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        set_votes('0, '0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
        chk("rst_tree_sel", tree_sel_o, 0);
        chk("rst_feat", feat_o, 0);
        chk("rst_reject", out_reject, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_votes(6'b000100, 6'b000100, 6'b000100, 6'b000100);
        send(1, 0);
        collect(0);

        set_votes(6'b010010, 6'b010010, 6'b010010, 6'b000000);
        send(1, 5);
        collect(5);

        set_votes(6'b100000, 6'b100000, 6'b100000, 6'b100000);
        send(0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_sel", tree_sel_o, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sel_clr", tree_sel_o, 0);
        chk("abort_valid", out_valid, 0);
        @(negedge clk);

        set_votes(6'b001000, 6'b000000, 6'b000000, 6'b000000);
        send(1, 0);
        collect(0);

        set_votes('0, '0, '0, '0);
        send(1, 0);
        collect(0);

        set_votes(6'b100000, 6'b100000, 6'b000000, 6'b000000);
        send(1, 2);
        collect(2);

        for (int k = 0; k < 4; k++) begin
            set_votes(N_CLASS'($urandom()), N_CLASS'($urandom()), N_CLASS'($urandom()), N_CLASS'($urandom()));
            send(1, k);
            collect(k);
        end

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
